if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline; the producer side of the IF/ID interface that the decode stage consumes.
- Owns the PC register.
- Issues requests to instruction memory using a req/ack handshake with wait states.
- Drives the IF/ID register (pc_4_out, ins).
- Applies the redirect (pc_src, branch, offset28, jr_target) that decode resolves, with one architectural delay slot.
- Honours the hazard-unit stall.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset.
NOP_INS, 32'h0000_0000, instruction word injected as a bubble.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
stall  input  1  hazard unit: hold PC and IF/ID; ignore pc_src.
pc_src  input  2  decode redirect: 00 = pc+4, 01 = branch, 10 = jump, 11 = register.
branch  input  32  branch target from decode.
offset28  input  28  jump offset, already shifted left by 2.
jr_target  input  32  register target (decode rs read data).
imem_req  output  1  fetch request.
imem_addr  output  32  fetch address; word aligned.
imem_ack  input  1  read data valid this cycle.
imem_rdata  input  32  instruction word.
pc_4_out  output  32  IF/ID: address of fetched instruction + 4.
ins  output  32  IF/ID: instruction word.
bubble_cnt  output  32  count of cycles in which a bubble entered IF/ID.

Behaviour:
- Reset (async, rst_n=0) values: pc=RESET_PC; ins=NOP_INS; pc_4_out=0; imem_req=0; state=S_FETCH; pend_vld=0; bubble_cnt=0; skid buffer cleared. The first request is issued in the first cycle after reset is released.
- Redirect target (combinational):
  - 01 → branch.
  - 10 → {pc_4_out[31:28], offset28}.
  - 11 → jr_target.
  - 00 → none.
- Redirect capture: when pc_src≠00 and stall=0, set pend_vld=1 and pend_pc=target. The fetch in flight or the next fetch is the delay slot and is always delivered. pc_src is ignored while stall=1.
- next_pc: pend_pc, or the live target if the redirect arrives in the same cycle; otherwise pc+4. All adds are mod 2^32, and the PC wraps from 32'hFFFF_FFFC to 0.
- FSM S_FETCH:
  - imem_req=1, imem_addr=pc. The address must stay stable until ack.
  - ack & !stall: ins←imem_rdata, pc_4_out←pc+4, pc←next_pc, pend_vld←0.
  - ack & stall: skid←imem_rdata; go to S_HELD.
  - !ack & !stall: ins←NOP_INS, pc_4_out held, bubble_cnt+1.
  - !ack & stall: IF/ID held.
- FSM S_HELD:
  - imem_req=0.
  - stall: hold everything.
  - !stall: ins←skid, pc_4_out←pc+4, pc←next_pc, pend_vld←0; go to S_FETCH.
- Latency: with ack every cycle and no stall, one instruction enters IF/ID per cycle. IF/ID is updated on the edge after ack.
- Redirect during a wait: a redirect that arrives while an ack is outstanding is held in pend_pc. The next redirect overwrites it, last one wins (legal only across a bubble).
- Reset mid-handshake: the request is dropped and any late ack is ignored, because imem_req=0 during reset.
- bubble_cnt saturates at 32'hFFFF_FFFF.

Decomposition:
- Package if_pkg:
  - pc_src encodings PC_SEQ, PC_BR, PC_J, PC_JR.
  - state encodings S_FETCH, S_HELD.
  - NOP_INS default.
- Sub-module pc_next_sel: combinational target mux plus pending-redirect select, producing next_pc.
- The FSM, the skid buffer and the IF/ID register stay in if_stage.

Test Plan:
- Reset release, ack every cycle, rdata = addr-tagged words → imem_addr 0, 4, 8; ins follows one cycle later; pc_4_out = 4, 8, 12; bubble_cnt=0.
- imem_ack delayed 3 cycles on address 8 → imem_addr held at 8; three NOP bubbles; bubble_cnt=3; then ins = word@8, pc_4_out = 12.
- Branch: the instruction at 0x10 in decode drives pc_src=01, branch=0x100 → the word at 0x14 (delay slot) enters IF/ID, then the fetch address is 0x100.
- Jump with pc_4_out=0x4000_0008, offset28=0x0000_0040 → after the delay slot, imem_addr=0x4000_0040. Also jr with jr_target=0x200 → 0x200.
- stall=1 for 2 cycles coincident with an ack → the skid buffer captures the word; ins/pc_4_out are unchanged for 2 cycles, then ins=skid word; pc_src=01 asserted during the stall has no effect.
- rst_n pulsed low while waiting for ack → outputs immediately return to reset values; a late ack is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared encodings for the instruction-fetch stage.
//   PC_SEQ/PC_BR/PC_J/PC_JR : decode redirect select (pc_src)
//   state_t                 : fetch FSM states
//   NOP_INS_DEFAULT         : bubble instruction word
//   word_align()            : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package if_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_J   = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HELD  = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INS_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_stage_pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
// Combinational next-PC selection for the fetch stage.
//   i_pc         : current fetch PC
//   i_pc_4_hi    : IF/ID pc_4_out[31:28], region bits for jumps
//   i_pc_src     : decode redirect select
//   i_stall      : hazard stall; a redirect is not taken while high
//   i_branch     : branch target
//   i_offset28   : jump offset, already shifted left by 2
//   i_jr_target  : register jump target
//   i_pend_vld   : a redirect has been captured and not yet applied
//   i_pend_pc    : captured redirect target
//   o_redirect   : a live redirect is present this cycle
//   o_target     : live redirect target
//   o_next_pc    : PC to load when the current fetch retires
// -----------------------------------------------------------------------------
module pc_next_sel
  import if_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [3:0]  i_pc_4_hi,
  input  logic [1:0]  i_pc_src,
  input  logic        i_stall,
  input  logic [31:0] i_branch,
  input  logic [27:0] i_offset28,
  input  logic [31:0] i_jr_target,
  input  logic        i_pend_vld,
  input  logic [31:0] i_pend_pc,
  output logic        o_redirect,
  output logic [31:0] o_target,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_seq_pc;
  logic [31:0] w_sel_pc;

  // Wraps naturally from 32'hFFFF_FFFC to 0.
  assign w_seq_pc = i_pc + 32'd4;

  always_comb begin
    o_target = 32'h0;
    case (i_pc_src)
      PC_BR:   o_target = i_branch;
      PC_J:    o_target = {i_pc_4_hi, i_offset28};
      PC_JR:   o_target = i_jr_target;
      default: o_target = 32'h0;
    endcase
  end

  assign o_redirect = (i_pc_src != PC_SEQ) && !i_stall;

  // A redirect arriving in the same cycle wins over an older captured one.
  always_comb begin
    w_sel_pc = w_seq_pc;
    if (o_redirect) begin
      w_sel_pc = o_target;
    end else if (i_pend_vld) begin
      w_sel_pc = i_pend_pc;
    end
  end

  assign o_next_pc = word_align(w_sel_pc);

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: owns the PC, fetches from instruction memory and
// drives the IF/ID register consumed by decode. Redirects from decode have one
// delay slot: the fetch in flight (or the next fetch) is always delivered.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   stall           : hazard hold of PC and IF/ID; pc_src ignored while high
//   pc_src          : redirect select (00 seq, 01 branch, 10 jump, 11 reg)
//   branch          : branch target
//   offset28        : jump offset (<<2 already applied)
//   jr_target       : register jump target
//   imem_req        : fetch request
//   imem_addr       : fetch address (word aligned)
//   imem_ack        : read data valid this cycle
//   imem_rdata      : instruction word
//   pc_4_out        : IF/ID fetched address + 4
//   ins             : IF/ID instruction word
//   bubble_cnt      : saturating count of bubbles entering IF/ID
//
// Memory handshake: while imem_req is high, imem_addr is held stable until a
// cycle with imem_ack high; imem_rdata is sampled in that cycle and the
// request completes. imem_ack is ignored whenever imem_req is low.
// -----------------------------------------------------------------------------
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = NOP_INS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch,
  input  logic [27:0] offset28,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_4_out,
  output logic [31:0] ins,
  output logic [31:0] bubble_cnt
);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_pc_4_out;
  logic [31:0] r_ins;
  logic [31:0] r_skid;
  logic        r_pend_vld;
  logic [31:0] r_pend_pc;
  logic [31:0] r_bubble_cnt;

  logic        w_req;
  logic        w_ack;
  logic        w_adv;
  logic        w_from_skid;
  logic        w_bubble;
  logic        w_skid_we;
  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_next_pc;
  logic [31:0] w_pc_plus4;

  pc_next_sel u_pc_next_sel (
    .i_pc        (r_pc),
    .i_pc_4_hi   (r_pc_4_out[31:28]),
    .i_pc_src    (pc_src),
    .i_stall     (stall),
    .i_branch    (branch),
    .i_offset28  (offset28),
    .i_jr_target (jr_target),
    .i_pend_vld  (r_pend_vld),
    .i_pend_pc   (r_pend_pc),
    .o_redirect  (w_redirect),
    .o_target    (w_target),
    .o_next_pc   (w_next_pc)
  );

  assign w_pc_plus4 = r_pc + 32'd4;

  // Gating with rst_n keeps the request low during reset, so a late ack from
  // a dropped transaction cannot be taken.
  assign w_req = rst_n && (r_state == S_FETCH);
  assign w_ack = imem_ack && w_req;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    w_from_skid = 1'b0;
    w_bubble    = 1'b0;
    w_skid_we   = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_ack && !stall) begin
          w_adv = 1'b1;
        end else if (w_ack && stall) begin
          // Memory completed but decode cannot take it: park the word.
          w_skid_we   = 1'b1;
          w_state_nxt = S_HELD;
        end else if (!stall) begin
          w_bubble = 1'b1;
        end
      end
      S_HELD: begin
        if (!stall) begin
          w_adv       = 1'b1;
          w_from_skid = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // PC, IF/ID, pending redirect and bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_pc_4_out   <= 32'h0;
      r_ins        <= NOP_INS;
      r_pend_vld   <= 1'b0;
      r_pend_pc    <= 32'h0;
      r_bubble_cnt <= 32'h0;
    end else begin
      if (w_adv) begin
        r_ins      <= w_from_skid ? r_skid : imem_rdata;
        r_pc_4_out <= w_pc_plus4;
        r_pc       <= w_next_pc;
        r_pend_vld <= 1'b0;
      end else begin
        if (w_bubble) begin
          r_ins <= NOP_INS;
          if (r_bubble_cnt != 32'hFFFF_FFFF) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
          end
        end
        // Redirect seen while the delay-slot fetch is still outstanding;
        // a later one overwrites it.
        if (w_redirect) begin
          r_pend_vld <= 1'b1;
          r_pend_pc  <= w_target;
        end
      end
    end
  end

  // Skid buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid <= 32'h0;
    end else if (w_skid_we) begin
      r_skid <= imem_rdata;
    end
  end

  assign imem_req   = w_req;
  assign imem_addr  = r_pc;
  assign pc_4_out   = r_pc_4_out;
  assign ins        = r_ins;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage. The memory model returns ~addr for every
// address, so each expected instruction word is ~(fetch address).
// -----------------------------------------------------------------------------
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [1:0]  pc_src;
  logic [31:0] branch;
  logic [27:0] offset28;
  logic [31:0] jr_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_4_out;
  logic [31:0] ins;
  logic [31:0] bubble_cnt;

  int n_checks = 0;
  int n_errors = 0;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INS  (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .pc_src     (pc_src),
    .branch     (branch),
    .offset28   (offset28),
    .jr_target  (jr_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc_4_out   (pc_4_out),
    .ins        (ins),
    .bubble_cnt (bubble_cnt)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = ~imem_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] e_ins,
                            input logic [31:0] e_pc4, input logic [31:0] e_addr);
    check({tag, ".ins"},  ins,       e_ins);
    check({tag, ".pc4"},  pc_4_out,  e_pc4);
    check({tag, ".addr"}, imem_addr, e_addr);
  endtask

  // advance one cycle; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".ins"}, ins,        32'h0);
    check({tag, ".pc4"}, pc_4_out,   32'h0);
    check({tag, ".req"}, {31'h0, imem_req}, 32'h0);
    check({tag, ".bub"}, bubble_cnt, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; pc_src = 2'b00; branch = '0;
    offset28 = '0; jr_target = '0; imem_ack = 1'b0;
    step(); step();
    check_reset_vals("rst");

    // reset release, ack every cycle
    rst_n = 1'b1;
    #1;
    check("rel.req",  {31'h0, imem_req}, 32'h1);
    check("rel.addr", imem_addr, 32'h0);
    imem_ack = 1'b1;
    step(); check_ifid("seq0", ~32'h0, 32'h4, 32'h8 - 32'h4);
    step(); check_ifid("seq1", ~32'h4, 32'h8, 32'h8);

    // ack delayed three cycles on address 8
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check_ifid("wait", 32'h0, 32'h8, 32'h8);
    end
    check("wait.bub", bubble_cnt, 32'd3);
    imem_ack = 1'b1;
    step(); check_ifid("wdone", ~32'h8, 32'hC, 32'hC);
    step(); check_ifid("seq3", ~32'hC, 32'h10, 32'h10);
    step(); check_ifid("seq4", ~32'h10, 32'h14, 32'h14);

    // branch from instruction at 0x10, delay slot at 0x14
    pc_src = 2'b01; branch = 32'h100;
    step(); check_ifid("br.ds", ~32'h14, 32'h18, 32'h100);
    pc_src = 2'b00;
    step(); check_ifid("br.tg", ~32'h100, 32'h104, 32'h104);

    // move into the 0x4000_0000 region
    pc_src = 2'b01; branch = 32'h4000_0000;
    step(); check_ifid("br2.ds", ~32'h104, 32'h108, 32'h4000_0000);
    pc_src = 2'b00;
    step(); step();
    check_ifid("j.pre", ~32'h4000_0004, 32'h4000_0008, 32'h4000_0008);

    // jump with pc_4_out = 0x4000_0008, offset28 = 0x40
    pc_src = 2'b10; offset28 = 28'h000_0040;
    step(); check_ifid("j.ds", ~32'h4000_0008, 32'h4000_000C, 32'h4000_0040);

    // register jump to 0x200
    pc_src = 2'b11; jr_target = 32'h200;
    step(); check_ifid("jr.ds", ~32'h4000_0040, 32'h4000_0044, 32'h200);
    pc_src = 2'b00;
    step(); check_ifid("jr.tg", ~32'h200, 32'h204, 32'h204);

    // redirect arriving while the delay-slot fetch waits for ack
    imem_ack = 1'b0; pc_src = 2'b01; branch = 32'h300;
    step(); check_ifid("pend.bub", 32'h0, 32'h204, 32'h204);
    check("pend.cnt", bubble_cnt, 32'd4);
    pc_src = 2'b00; imem_ack = 1'b1;
    step(); check_ifid("pend.ds", ~32'h204, 32'h208, 32'h300);
    step(); check_ifid("pend.tg", ~32'h300, 32'h304, 32'h304);

    // stall for two cycles coincident with ack; redirect during stall ignored
    stall = 1'b1; pc_src = 2'b01; branch = 32'h500;
    step(); check_ifid("stl1", ~32'h300, 32'h304, 32'h304);
    check("stl1.req", {31'h0, imem_req}, 32'h0);
    step(); check_ifid("stl2", ~32'h300, 32'h304, 32'h304);
    stall = 1'b0; pc_src = 2'b00;
    step(); check_ifid("skid", ~32'h304, 32'h308, 32'h308);
    check("skid.req", {31'h0, imem_req}, 32'h1);
    check("skid.bub", bubble_cnt, 32'd4);

    // reset while waiting for ack; late ack during reset is ignored
    imem_ack = 1'b0;
    step(); check("mid.bub", bubble_cnt, 32'd5);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid.rst");
    check("mid.addr", imem_addr, 32'h0);
    imem_ack = 1'b1;
    step(); step();
    check_reset_vals("late");
    imem_ack = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst2.addr", imem_addr, 32'h0);
    check("rst2.req",  {31'h0, imem_req}, 32'h1);
    imem_ack = 1'b1;
    step(); check_ifid("rst2.f0", ~32'h0, 32'h4, 32'h4);

    // PC wrap from 0xFFFF_FFFC to 0
    pc_src = 2'b11; jr_target = 32'hFFFF_FFFC;
    step(); check_ifid("wrap.ds", ~32'h4, 32'h8, 32'hFFFF_FFFC);
    pc_src = 2'b00;
    step(); check_ifid("wrap", 32'h0000_0003, 32'h0, 32'h0);
    check("wrap.bub", bubble_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
